// File: rtl/hog_block_norm.sv
// hog_block_norm: collects one HOG block (N_BIN bins) into a ping-pong bank,
// forms the L1 sum, then streams every (bin, sum) pair through a pipelined
// fractional divider and emits bin/sum as an unsigned Q0.OUT_W fraction.

// div2: fixed-latency restoring divider producing floor(a * 2^Q_W / b) for a <= b.
// Each of the LAT stages resolves Q_W/LAT quotient bits.
module div2 #(
    parameter int A_W = 20,
    parameter int B_W = 22,
    parameter int Q_W = 32,
    parameter int LAT = 16
) (
    input  logic           clk,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [Q_W-1:0] o
);
    localparam int BPS = Q_W / LAT;
    localparam int R_W = B_W + 1;

    // Remainder stays below 2*b, so one bit above the divisor width is enough.
    function automatic logic [R_W+BPS-1:0] div_iter(input logic [R_W-1:0] rem_in,
                                                    input logic [B_W-1:0] den);
        logic [R_W-1:0] r;
        logic [R_W:0]   sh;
        logic [BPS-1:0] q;
        r = rem_in;
        q = '0;
        for (int i = 0; i < BPS; i++) begin
            sh = {r, 1'b0};
            q  = q << 1;
            if (sh >= {2'b00, den}) begin
                sh   = sh - {2'b00, den};
                q[0] = 1'b1;
            end else begin
                q[0] = 1'b0;
            end
            r = sh[R_W-1:0];
        end
        return {r, q};
    endfunction

    logic [R_W-1:0]     rem_in [LAT];
    logic [B_W-1:0]     den_in [LAT];
    logic [R_W+BPS-1:0] step   [LAT];
    logic [R_W-1:0]     rem_r  [LAT-1];
    logic [B_W-1:0]     den_r  [LAT-1];
    logic [Q_W-1:0]     quo_r  [LAT];
    logic [R_W-1:0]     rem_last_unused;

    assign rem_in[0] = {{(R_W-A_W){1'b0}}, a};
    assign den_in[0] = b;
    assign rem_last_unused = step[LAT-1][R_W+BPS-1:BPS];
    assign o = quo_r[LAT-1];

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        if (s > 0) begin : g_link
            assign rem_in[s] = rem_r[s-1];
            assign den_in[s] = den_r[s-1];
        end
        assign step[s] = div_iter(rem_in[s], den_in[s]);

        // Quotient bits land at a fixed position so every stage carries all Q_W bits.
        always_ff @(posedge clk) begin
            if (s == 0) begin
                quo_r[s] <= {step[s][BPS-1:0], {(Q_W-BPS){1'b0}}};
            end else begin
                quo_r[s] <= quo_r[(s > 0) ? s-1 : 0];
                quo_r[s][Q_W-1-s*BPS -: BPS] <= step[s][BPS-1:0];
            end
        end

        if (s < LAT-1) begin : g_rem
            // Partial remainder and divisor travel with the quotient.
            always_ff @(posedge clk) begin
                rem_r[s] <= step[s][R_W+BPS-1:BPS];
                den_r[s] <= den_in[s];
            end
        end
    end
endmodule

module hog_block_norm #(
    parameter int BIN_W   = 16,
    parameter int N_BIN   = 36,
    parameter int SUM_W   = 22,
    parameter int OUT_W   = 16,
    parameter int DIV_LAT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_norm,
    output logic             out_last
);
    localparam int A_W   = 20;
    localparam int Q_W   = 32;
    localparam int IDX_W = $clog2(N_BIN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BIN - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [BIN_W-1:0] bank_mem [2][N_BIN];
    logic [SUM_W-1:0] bank_sum [2];
    logic [1:0]       full;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    state_t           state;
    state_t           state_next;
    logic             issue;
    logic             issue_last;
    logic             accept;

    logic [BIN_W-1:0] issue_bin;
    logic [SUM_W-1:0] issue_sum;
    logic             issue_zero;
    logic             issue_sat;

    logic [DIV_LAT-1:0] sb_valid;
    logic [DIV_LAT-1:0] sb_last;
    logic [DIV_LAT-1:0] sb_zero;
    logic [DIV_LAT-1:0] sb_sat;

    logic [Q_W-1:0]       div_q;
    logic [Q_W-OUT_W-1:0] div_lo_unused;

    assign in_ready      = !full[wr_bank];
    assign accept        = in_valid && in_ready;
    assign issue_bin     = bank_mem[rd_bank][rd_idx];
    assign issue_sum     = bank_sum[rd_bank];
    assign issue_zero    = (issue_sum == {SUM_W{1'b0}});
    assign issue_sat     = ({{(SUM_W-BIN_W){1'b0}}, issue_bin} == issue_sum) && !issue_zero;
    assign div_lo_unused = div_q[Q_W-OUT_W-1:0];

    // Bin storage; a bank is only written while it is not full.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[wr_bank][wr_idx] <= in_bin;
        end
    end

    // Write pointer, running L1 sum and the full flags (set by writer, cleared by issuer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            bank_sum[0] <= '0;
            bank_sum[1] <= '0;
            full        <= 2'b00;
        end else begin
            if (accept) begin
                if (wr_idx == {IDX_W{1'b0}}) begin
                    bank_sum[wr_bank] <= {{(SUM_W-BIN_W){1'b0}}, in_bin};
                end else begin
                    bank_sum[wr_bank] <= bank_sum[wr_bank] + {{(SUM_W-BIN_W){1'b0}}, in_bin};
                end
                if (wr_idx == IDX_LAST) begin
                    wr_idx        <= '0;
                    wr_bank       <= !wr_bank;
                    full[wr_bank] <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (issue_last) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Issue FSM next-state: drain a full bank one pair per cycle, chain banks without a bubble.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (rd_idx == IDX_LAST) begin
                    issue_last = 1'b1;
                    if (full[!rd_bank]) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Issue FSM state, read index and read bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_next;
            if (issue_last) begin
                rd_idx  <= '0;
                rd_bank <= !rd_bank;
            end else if (issue) begin
                rd_idx <= rd_idx + 1'b1;
            end else begin
                rd_idx <= '0;
            end
        end
    end

    div2 #(.A_W(A_W), .B_W(SUM_W), .Q_W(Q_W), .LAT(DIV_LAT)) u_div2 (
        .clk (clk),
        .a   ({{(A_W-BIN_W){1'b0}}, issue_bin}),
        .b   (issue_sum),
        .o   (div_q)
    );

    // Side-band flags aligned with the divider pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_last  <= '0;
            sb_zero  <= '0;
            sb_sat   <= '0;
        end else begin
            sb_valid <= {sb_valid[DIV_LAT-2:0], issue};
            sb_last  <= {sb_last[DIV_LAT-2:0], issue_last};
            sb_zero  <= {sb_zero[DIV_LAT-2:0], issue_zero};
            sb_sat   <= {sb_sat[DIV_LAT-2:0], issue_sat};
        end
    end

    // Output register: zero sum gives 0, bin equal to sum saturates, else truncated quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_norm  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= sb_valid[DIV_LAT-1];
            if (sb_valid[DIV_LAT-1]) begin
                out_last <= sb_last[DIV_LAT-1];
                if (sb_zero[DIV_LAT-1]) begin
                    out_norm <= '0;
                end else if (sb_sat[DIV_LAT-1]) begin
                    out_norm <= '1;
                end else begin
                    out_norm <= div_q[Q_W-1 -: OUT_W];
                end
            end else begin
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: doc/hog_block_norm.md
# hog_block_norm

Upstream feeder and result formatter for the `div2` fractional divider in the HOG descriptor path. Collects the 36 histogram bins of one HOG block (4 cells × 9 bins), computes their L1 sum, then streams each (bin, sum) pair through an internal `div2` instance. It emits the normalized bins as Q0.16 fractions with fixed latency, ready for the SVM dot-product stage. It uses ping-pong bank buffering so the next block can be collected while the current one is being divided.

## Interface

Parameters:
- BIN_W, 16, input bin width (unsigned); zero-extended to `div2` A_W=20
- N_BIN, 36, bins per block
- SUM_W, 22, L1 sum width; equals `div2` B_W; N_BIN·(2^BIN_W−1) fits
- OUT_W, 16, output fraction width, MSBs of `div2` Q0.32 result
- DIV_LAT, 16, `div2` pipeline latency in cycles; fixed

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  bin on in_bin is valid
- in_ready  out  1  block can accept a bin this cycle
- in_bin  in  BIN_W  histogram bin; block order, index 0 first
- out_valid  out  1  out_norm valid; no backpressure
- out_norm  out  OUT_W  normalized bin, unsigned Q0.OUT_W
- out_last  out  1  high with bin N_BIN−1 of a block

## Operation

- Two banks, each holding N_BIN × BIN_W bins plus a SUM_W sum and a full flag.
- Write side:
  - A bin is accepted when in_valid & in_ready. It goes to wr_bank[wr_idx], and the bank's sum accumulates it.
  - wr_idx counts 0..N_BIN−1.
  - On accepting index N_BIN−1, the bank's full flag is set, wr_idx returns to 0, and wr_bank toggles.
  - in_ready = !full[wr_bank].
- Issue side, FSM with states IDLE and ISSUE:
  - IDLE → ISSUE when full[rd_bank] is set. rd_idx = 0.
  - In ISSUE, one pair per cycle is driven to `div2`: a = zero-extended bank[rd_idx], b = sum.
  - After issuing rd_idx = N_BIN−1: clear full[rd_bank], toggle rd_bank, go to IDLE. If the other bank is already full, go directly to ISSUE with no bubble.
- Side-band pipeline, DIV_LAT deep, travels alongside `div2`. Per issued pair it carries valid, last, zero (sum==0) and sat (bin==sum and sum≠0).
- Output register, loaded when the side-band valid emerges:
  - zero → out_norm = 0
  - sat → out_norm = all ones (2^OUT_W−1)
  - otherwise out_norm = `div2` o[31 : 32−OUT_W] (truncated, no rounding)
- Width rules: the sum never overflows for N_BIN=36 and BIN_W=16. The bin is compared to the sum at full SUM_W width.
- Write and issue of the same bank never overlap: writing requires !full, and issuing requires full.
- Clearing a full flag and the write side's view of it take effect on the same edge. in_ready rises the cycle after the last issue of that bank.

## Timing

- Reset values:
  - in_ready = 1
  - out_valid = 0, out_norm = 0, out_last = 0
  - full flags, indices and sums = 0
  - wr_bank = rd_bank = 0, FSM = IDLE, side-band valids = 0
- Reset mid-operation discards the partial block, both banks and all in-flight results. No out_valid appears after reset deasserts until a new full block arrives.
- Issue latency: a pair issued in cycle t produces out_valid in cycle t+DIV_LAT+1 = t+17.
- Block latency: last bin accepted at edge T gives the first issue in cycle T+1 and out_valid for bin 0 at T+18.
- A block's outputs are N_BIN consecutive out_valid cycles. Back-to-back full banks give continuous out_valid.
- Throughput: one bin per cycle sustained. in_ready drops only when both banks are full.
- out_valid is never stalled. The consumer must accept every cycle.

## Test plan

- Reset, then a block of 36 bins all = 100 (sum 3600). Required: out_valid for 36 consecutive cycles starting 18 cycles after the last accept. Each out_norm = floor(2^16/36) = 1820. out_last is high on the 36th output only.
- A block with bin 5 = 1000 and all others 0. Required: out_norm 0xFFFF at index 5 (saturation) and 0 elsewhere.
- An all-zero block. Required: 36 outputs = 0, no X, no overflow wrap.
- Three blocks streamed back-to-back with in_valid held high. Required: in_ready low for exactly the cycles where both banks are full. Outputs arrive in order with no gaps between blocks 1 and 2.
- Bins 0..35 equal to i+1 (sum 666). Required: out_norm[i] = floor((i+1)·65536/666) for each i, e.g. bin 0 = 98, bin 35 = 3542.
- Assert rst for 1 cycle while block 1 is mid-issue and block 2 is half-written. Required: all outputs 0 immediately and in_ready = 1. No stale out_valid appears during the following 17 cycles, and a fresh block then processes correctly.
